dsr_shift_chain: RTL and testbench

//   Parametrised successor to the single set/reset flip-flop test cell.

---
 rtl/dsr_pkg.sv | 23 ++
 rtl/dsr_bit_cell.sv | 35 +++
 rtl/dsr_shift_chain.sv | 86 ++++++++
 tb/tb_dsr_shift_chain.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dsr_pkg.sv
// Shared mode encoding and priority decode for the set/reset shift chain.
package dsr_pkg;

  typedef enum logic [1:0] {
    DSR_HOLD,
    DSR_SHIFT,
    DSR_LOAD,
    DSR_SET
  } dsr_mode_e;

  // set beats load beats shift
  function automatic dsr_mode_e dsr_mode(
    input logic set,
    input logic load,
    input logic shift_en
  );
    if (set)           return DSR_SET;
    else if (load)     return DSR_LOAD;
    else if (shift_en) return DSR_SHIFT;
    else               return DSR_HOLD;
  endfunction

endpackage

// File: rtl/dsr_bit_cell.sv
// One chain flop: async reset to its own reset bit, sync mode mux.
module dsr_bit_cell
  import dsr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  dsr_mode_e mode_i,
  input  logic      ser_i,
  input  logic      par_i,
  output logic      q_o
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    unique case (mode_i)
      DSR_SET:   bit_d = 1'b1;
      DSR_LOAD:  bit_d = par_i;
      DSR_SHIFT: bit_d = ser_i;
      default:   bit_d = bit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bit_q <= RST_BIT;
    else       bit_q <= bit_d;
  end

  assign q_o = bit_q;

endmodule

// File: rtl/dsr_shift_chain.sv
// WIDTH-flop set/reset chain with parallel load, serial shift
// and a saturating fill counter that pulses done on the last fill shift.
module dsr_shift_chain
  import dsr_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             set,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             q_ser,
  output logic             notq_ser,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  dsr_mode_e        mode;
  logic [WIDTH-1:0] chain_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;
  logic             done_d;

  assign mode = dsr_mode(set, load, shift_en);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ser;
    if (i == 0) begin : g_head
      assign ser = data;
    end else begin : g_body
      assign ser = chain_q[i-1];
    end
    dsr_bit_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .mode_i (mode),
      .ser_i  (ser),
      .par_i  (par_in[i]),
      .q_o    (chain_q[i])
    );
  end

  // A load counts as a full chain, but only a shift may pulse done
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    unique case (mode)
      DSR_SET:  count_d = '0;
      DSR_LOAD: count_d = FULL;
      DSR_SHIFT: begin
        if (count_q != FULL) count_d = count_q + 1'b1;
        done_d = (count_q == LAST);
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign q        = chain_q;
  assign q_ser    = chain_q[WIDTH-1];
  assign notq_ser = ~chain_q[WIDTH-1];
  assign count    = count_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dsr_shift_chain.sv
// Directed bench for dsr_shift_chain: reference model compared every
// cycle plus literal expectations, and a RESET_VAL=0xA5 instance.
module tb_dsr_shift_chain;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data = 1'b0;
  logic         set = 1'b0;
  logic         load = 1'b0;
  logic         shift_en = 1'b0;
  logic [W-1:0] par_in = '0;
  logic [W-1:0] q;
  logic         q_ser;
  logic         notq_ser;
  logic [3:0]   count;
  logic         done;

  logic         reset_b = 1'b1;
  logic         zero_b = 1'b0;
  logic [W-1:0] par_b = '0;
  logic [W-1:0] q_b;
  logic         q_ser_b;
  logic         notq_ser_b;
  logic [3:0]   count_b;
  logic         done_b;

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dsr_shift_chain #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .set      (set),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (par_in),
    .q        (q),
    .q_ser    (q_ser),
    .notq_ser (notq_ser),
    .count    (count),
    .done     (done)
  );

  dsr_shift_chain #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .data     (zero_b),
    .set      (zero_b),
    .load     (zero_b),
    .shift_en (zero_b),
    .par_in   (par_b),
    .q        (q_b),
    .q_ser    (q_ser_b),
    .notq_ser (notq_ser_b),
    .count    (count_b),
    .done     (done_b)
  );

  // Reference: chain as an integer word, count as a plain integer
  int  m_word = 0;
  int  m_cnt = 0;
  bit  m_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_word <= 0;
      m_cnt  <= 0;
      m_done <= 0;
    end else if (set) begin
      m_word <= (1 << W) - 1;
      m_cnt  <= 0;
      m_done <= 0;
    end else if (load) begin
      m_word <= int'(par_in);
      m_cnt  <= W;
      m_done <= 0;
    end else if (shift_en) begin
      m_word <= ((m_word * 2) + int'(data)) % (1 << W);
      m_cnt  <= (m_cnt + 1 > W) ? W : m_cnt + 1;
      m_done <= (m_cnt + 1 == W);
    end else begin
      m_done <= 0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_q", int'(q), m_word);
      chk("cyc_count", int'(count), m_cnt);
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_qser", int'(q_ser), (m_word >> (W - 1)) & 1);
      chk("cyc_notq", int'(notq_ser), ((m_word >> (W - 1)) & 1) ^ 1);
    end
  end

  // Apply inputs now, then land 3 ns after the next rising edge
  task automatic cyc(input logic s, input logic l, input logic sh,
                     input logic d, input logic [W-1:0] p);
    set = s; load = l; shift_en = sh; data = d; par_in = p;
    @(posedge clk);
    #3;
    set = 0; load = 0; shift_en = 0; data = 0; par_in = '0;
  endtask

  logic [7:0] pat;

  initial begin
    @(posedge clk);
    #3;
    chk("rst_q", int'(q), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(done), 0);
    chk("rstb_q", int'(q_b), 'hA5);
    chk("rstb_qser", int'(q_ser_b), 1);
    chk("rstb_notq", int'(notq_ser_b), 0);
    reset = 0;
    cmp_en = 1;

    // 1: async reset mid-cycle
    cyc(0, 1, 0, 0, 8'h3C);
    chk("t1_pre_q", int'(q), 'h3C);
    reset = 1;
    #1;
    chk("t1_async_q", int'(q), 0);
    chk("t1_async_count", int'(count), 0);
    chk("t1_async_done", int'(done), 0);
    chk("t1_async_notq", int'(notq_ser), 1);
    reset = 0;

    // 2: eight fill shifts then one saturating shift
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, pat[7-i], 8'h00);
      if (i == 6) begin
        chk("t2_count7", int'(count), 7);
        chk("t2_nodone7", int'(done), 0);
      end
    end
    chk("t2_q", int'(q), 'hB2);
    chk("t2_count", int'(count), 8);
    chk("t2_done", int'(done), 1);
    cyc(0, 0, 1, 1, 8'h00);
    chk("t2_sat_q", int'(q), 'h65);
    chk("t2_sat_count", int'(count), 8);
    chk("t2_sat_done", int'(done), 0);
    cyc(0, 0, 0, 1, 8'hFF);
    chk("t2_hold_q", int'(q), 'h65);

    // 3: load then set
    cyc(0, 1, 0, 0, 8'h5A);
    chk("t3_load_q", int'(q), 'h5A);
    chk("t3_load_count", int'(count), 8);
    chk("t3_load_done", int'(done), 0);
    cyc(1, 0, 0, 0, 8'h00);
    chk("t3_set_q", int'(q), 'hFF);
    chk("t3_set_count", int'(count), 0);
    chk("t3_set_qser", int'(q_ser), 1);
    chk("t3_set_notq", int'(notq_ser), 0);

    // 4: set wins over load and shift
    cyc(0, 1, 0, 0, 8'h12);
    cyc(1, 1, 1, 0, 8'h00);
    chk("t4_q", int'(q), 'hFF);
    chk("t4_count", int'(count), 0);

    // 5: partial fill, reset between edges, resume
    cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t5_mid_q", int'(q), 'hFE);
    chk("t5_mid_count", int'(count), 3);
    reset = 1;
    #2;
    chk("t5_rst_q", int'(q), 0);
    chk("t5_rst_count", int'(count), 0);
    reset = 0;
    cyc(0, 0, 1, 1, 8'h00);
    chk("t5_q", int'(q), 'h01);
    chk("t5_count", int'(count), 1);

    // 6: non-zero reset value holds after release
    reset_b = 0;
    repeat (4) cyc(0, 0, 0, 0, 8'h00);
    chk("t6_q", int'(q_b), 'hA5);
    chk("t6_count", int'(count_b), 0);
    chk("t6_done", int'(done_b), 0);
    reset_b = 1;
    #1;
    chk("t6_rst_q", int'(q_b), 'hA5);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
